// File: rtl/acq_pkg.sv
// acq_pkg: definitions shared by the acquisition sequencer.
//   - command opcodes carried in cmd[15:12]
//   - sequencer state encoding
//   - bit positions of the STATUS word returned on tx_data
//   - pack_status(): assembles the STATUS word from its fields
package acq_pkg;

   typedef enum logic [3:0] {
      OP_START     = 4'd1,
      OP_STOP      = 4'd2,
      OP_READ      = 4'd3,
      OP_STATUS    = 4'd4,
      OP_RDPTR_CLR = 4'd5
   } acq_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_COUNT = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } acq_state_e;

   localparam int STAT_BUSY_BIT = 15;
   localparam int STAT_DONE_BIT = 14;
   localparam int STAT_SAT_BIT  = 13;
   localparam int STAT_ERR_BIT  = 12;
   localparam int STAT_PTR_W    = 10;

   // Bits 11:10 are reserved and always read as zero.
   function automatic logic [15:0] pack_status(input logic                  busy,
                                               input logic                  done,
                                               input logic                  sat,
                                               input logic                  err,
                                               input logic [STAT_PTR_W-1:0] ptr);
      logic [15:0] s;
      s                   = '0;
      s[STAT_PTR_W-1:0]   = ptr;
      s[STAT_BUSY_BIT]    = busy;
      s[STAT_DONE_BIT]    = done;
      s[STAT_SAT_BIT]     = sat;
      s[STAT_ERR_BIT]     = err;
      return s;
   endfunction

endpackage

// File: rtl/dmd_edge_sync.sv
// dmd_edge_sync: brings the asynchronous DMD pattern-change signal into the
// clk domain and emits a one-cycle pulse on each rising edge.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   async_i in  raw DMD pattern-change signal (at least 2 clk wide)
//   edge_o  out registered rising-edge pulse, high in the 3rd cycle after
//               the cycle in which async_i was first sampled high
module dmd_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic edge_q;

   // sync1/sync2 form the metastability guard; prev holds the last settled
   // value so the edge can be registered (clean glitch-free pulse).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         edge_q  <= sync2_q & ~prev_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: frame acquisition sequencer for a DMD-driven photon counter.
// Each DMD pattern change closes one counting window; the count of that
// window is written to frame memory. Commands arrive from an SPI front end.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   cmd[15:0], cmd_valid    command word ([15:12] opcode, [ADDR_W-1:0] arg)
//   dmd_sig                 asynchronous DMD pattern-change pulse
//   cnt[15:0]               photon counter value
//   cnt_clr, cnt_en         counter clear strobe and gate
//   mem_we/waddr/wdata      frame-memory write port
//   mem_raddr, mem_rdata    frame-memory read port (1-cycle read latency)
//   tx_data[15:0]           word for the next SPI transfer
//   busy                    acquisition in progress (ARM/COUNT/LATCH)
//   state_dbg[2:0]          current sequencer state (acq_state_e encoding)
//
// Command interface: cmd_valid is a valid-only strobe with no ready/backpressure;
// a command is consumed in exactly the cycle cmd_valid is high, and cmd is
// ignored whenever cmd_valid is low.
module acq_sequencer
   import acq_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       cmd,
   input  logic              cmd_valid,
   input  logic              dmd_sig,
   input  logic [15:0]       cnt,
   output logic              cnt_clr,
   output logic              cnt_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       tx_data,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   // One extra bit so a frame count of 2^ADDR_W is representable.
   localparam int PTR_W = ADDR_W + 1;

   acq_state_e        state_q, state_d;
   logic [PTR_W-1:0]  n_frames_q, n_frames_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              sat_q, sat_d;
   logic              err_q, err_d;
   logic              cnt_clr_q, cnt_clr_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_ok_q, rd_ok_d;
   logic [15:0]       tx_data_q, tx_data_d;

   logic              dmd_edge;
   logic [3:0]        op;
   logic [ADDR_W-1:0] arg;
   logic              is_start, is_stop, is_read, is_status, is_rdclr;
   logic              busy_w;
   logic              rd_ok;
   logic              last_frame;
   logic              unused_cmd;

   dmd_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (dmd_sig),
      .edge_o  (dmd_edge)
   );

   assign op        = cmd[15:12];
   assign arg       = cmd[ADDR_W-1:0];
   assign is_start  = cmd_valid && (op == OP_START);
   assign is_stop   = cmd_valid && (op == OP_STOP);
   assign is_read   = cmd_valid && (op == OP_READ);
   assign is_status = cmd_valid && (op == OP_STATUS);
   assign is_rdclr  = cmd_valid && (op == OP_RDPTR_CLR);
   // Reserved argument bits between ADDR_W and the opcode carry no meaning.
   assign unused_cmd = ^cmd;

   assign busy_w     = (state_q == ST_ARM) || (state_q == ST_COUNT) || (state_q == ST_LATCH);
   assign rd_ok      = ({1'b0, rd_ptr_q} < wr_ptr_q);
   assign last_frame = ((wr_ptr_q + PTR_W'(1)) == n_frames_q);

   // Sequencer: next state, frame bookkeeping and flags.
   always_comb begin
      state_d    = state_q;
      n_frames_d = n_frames_q;
      wr_ptr_d   = wr_ptr_q;
      sat_d      = sat_q;
      err_d      = err_q;
      cnt_clr_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (is_start) begin
               state_d    = ST_ARM;
               // An argument of zero requests the full memory depth.
               n_frames_d = (arg == '0) ? (PTR_W'(1) << ADDR_W) : {1'b0, arg};
               wr_ptr_d   = '0;
               sat_d      = 1'b0;
               err_d      = 1'b0;
               cnt_clr_d  = 1'b1;
            end
         end
         ST_ARM: begin
            // First edge only aligns the counting window to the pattern.
            if (is_stop) begin
               state_d = ST_IDLE;
            end else if (dmd_edge) begin
               state_d   = ST_COUNT;
               cnt_clr_d = 1'b1;
            end
         end
         ST_COUNT: begin
            // STOP has priority over a coincident edge so no frame is written.
            if (is_stop) begin
               state_d = ST_IDLE;
            end else if (dmd_edge) begin
               state_d   = ST_LATCH;
               cnt_clr_d = 1'b1;
            end
         end
         ST_LATCH: begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (cnt == 16'hFFFF) begin
               sat_d = 1'b1;
            end
            if (is_stop) begin
               state_d = ST_IDLE;
            end else if (last_frame) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_COUNT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (is_start && busy_w) begin
         err_d = 1'b1;
      end
      if (is_read && !rd_ok) begin
         err_d = 1'b1;
      end
   end

   // Readback path: READ samples mem_raddr at the command edge, memory data
   // arrives one cycle later and is registered into tx_data the cycle after.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      rd_pend_d = 1'b0;
      rd_ok_d   = rd_ok_q;
      tx_data_d = tx_data_q;

      if (rd_pend_q) begin
         tx_data_d = rd_ok_q ? mem_rdata : 16'h0000;
      end
      if (is_read) begin
         rd_pend_d = 1'b1;
         rd_ok_d   = rd_ok;
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
      end
      if (is_status) begin
         tx_data_d = pack_status(busy_w, state_q == ST_DONE, sat_q, err_q,
                                 STAT_PTR_W'(wr_ptr_q));
      end
      if (is_rdclr) begin
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         n_frames_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sat_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_clr_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_ok_q    <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         n_frames_q <= n_frames_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sat_q      <= sat_d;
         err_q      <= err_d;
         cnt_clr_q  <= cnt_clr_d;
         rd_pend_q  <= rd_pend_d;
         rd_ok_q    <= rd_ok_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Outputs decode directly from the state register so reset clears them
   // without waiting for a clock.
   assign cnt_en    = (state_q == ST_COUNT);
   assign mem_we    = (state_q == ST_LATCH);
   assign mem_waddr = wr_ptr_q[ADDR_W-1:0];
   assign mem_wdata = mem_we ? cnt : 16'h0000;
   assign mem_raddr = rd_ptr_q;
   assign cnt_clr   = cnt_clr_q;
   assign tx_data   = tx_data_q;
   assign busy      = busy_w;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Testbench for acq_sequencer: directed command/DMD sequences, a cycle-level
// behavioural model compared against every output each cycle, and literal
// expectations at key points of each scenario.
module tb_acq_sequencer;

   localparam int AW  = 10;
   localparam int GAP = 360;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   cmd;
   logic          cmd_valid;
   logic          dmd_sig;
   logic [15:0]   cnt;
   logic          cnt_clr;
   logic          cnt_en;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [15:0]   mem_wdata;
   logic [AW-1:0] mem_raddr;
   logic [15:0]   mem_rdata;
   logic [15:0]   tx_data;
   logic          busy;
   logic [2:0]    state_dbg;

   always #5 clk = ~clk;

   acq_sequencer #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .dmd_sig   (dmd_sig),
      .cnt       (cnt),
      .cnt_clr   (cnt_clr),
      .cnt_en    (cnt_en),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .tx_data   (tx_data),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Frame memory attached to the DUT (synchronous read, 1-cycle latency).
   logic [15:0] fmem [0:1023];
   always @(posedge clk) begin
      if (mem_we) fmem[mem_waddr] <= mem_wdata;
      mem_rdata <= fmem[mem_raddr];
   end

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_err    = 0;
   int wr_seen  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Modes: 0 idle, 1 waiting for aligning edge, 2 counting, 3 writing, 4 done
   int          m_mode;
   int          m_n, m_wr, m_rd;
   bit          m_sat, m_err, m_clr, m_pend;
   logic [15:0] m_tx, m_pend_val;
   logic [15:0] m_mem [0:1023];
   logic [3:0]  m_h;   // m_h[k] = dmd_sig seen k+1 cycles ago

   task automatic model_reset();
      m_mode = 0; m_n = 0; m_wr = 0; m_rd = 0;
      m_sat = 0; m_err = 0; m_clr = 0; m_pend = 0;
      m_tx = 16'h0000; m_pend_val = 16'h0000; m_h = 4'b0000;
   endtask

   always @(negedge clk) begin : cmp_proc
      bit          e_busy, e_done, m_edge, clr_next, rd_ok;
      logic [3:0]  op;
      int          arg;
      logic [15:0] stat;
      if (!rst_n) begin
         model_reset();
         chk("rst_cnt_en", cnt_en, 0);
         chk("rst_cnt_clr", cnt_clr, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_busy", busy, 0);
         chk("rst_tx", tx_data, 0);
      end else begin
         e_busy = (m_mode >= 1 && m_mode <= 3);
         e_done = (m_mode == 4);
         if (mem_we === 1'b1) wr_seen++;
         chk("busy", busy, e_busy);
         chk("cnt_en", cnt_en, m_mode == 2);
         chk("cnt_clr", cnt_clr, m_clr);
         chk("mem_we", mem_we, m_mode == 3);
         if (m_mode == 3) begin
            chk("mem_waddr", mem_waddr, m_wr % 1024);
            chk("mem_wdata", mem_wdata, cnt);
         end
         chk("mem_raddr", mem_raddr, m_rd);
         chk("tx_data", tx_data, m_tx);

         // advance using this cycle's inputs and pre-update state
         op       = cmd_valid ? cmd[15:12] : 4'd0;
         arg      = int'(cmd[AW-1:0]);
         m_edge   = m_h[2] & ~m_h[3];
         clr_next = 0;
         rd_ok    = (m_rd < m_wr);
         stat     = 16'(m_wr % 1024);
         stat[15] = e_busy;
         stat[14] = e_done;
         stat[13] = m_sat;
         stat[12] = m_err;

         if (m_pend) begin
            m_tx   = m_pend_val;
            m_pend = 0;
         end

         case (m_mode)
            0, 4: if (op == 4'd1) begin
               m_mode = 1; m_n = (arg == 0) ? 1024 : arg;
               m_wr = 0; m_sat = 0; m_err = 0; clr_next = 1;
            end
            1: if (op == 4'd2) m_mode = 0;
               else if (m_edge) begin m_mode = 2; clr_next = 1; end
            2: if (op == 4'd2) m_mode = 0;
               else if (m_edge) begin m_mode = 3; clr_next = 1; end
            3: begin
               m_mem[m_wr % 1024] = cnt;
               if (cnt == 16'hFFFF) m_sat = 1;
               m_wr++;
               if (op == 4'd2) m_mode = 0;
               else if (m_wr == m_n) m_mode = 4;
               else m_mode = 2;
            end
            default: m_mode = 0;
         endcase
         if (op == 4'd1 && e_busy) m_err = 1;

         if (op == 4'd3) begin
            m_pend = 1;
            if (rd_ok) begin
               m_pend_val = m_mem[m_rd];
               m_rd = (m_rd + 1) % 1024;
            end else begin
               m_pend_val = 16'h0000;
               m_err = 1;
            end
         end
         if (op == 4'd4) m_tx = stat;
         if (op == 4'd5) m_rd = 0;
         m_clr = clr_next;
         m_h = {m_h[2:0], dmd_sig};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] op, input int arg);
      cmd       = {op, 12'(arg)};
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd       = 16'h0000;
   endtask

   // Count value is held from the pattern change until the next one.
   task automatic pulse(input logic [15:0] v);
      cnt     = v;
      dmd_sig = 1'b1;
      step(3);
      dmd_sig = 1'b0;
      step(GAP - 3);
   endtask

   task automatic status_expect(input string name, input logic [15:0] exp);
      send(4'd4, 0);
      chk(name, tx_data, exp);
   endtask

   task automatic read_expect(input string name, input logic [15:0] exp);
      send(4'd3, 0);
      step();
      chk(name, tx_data, exp);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : main
      int w0;
      for (int i = 0; i < 1024; i++) fmem[i] = 16'h0000;
      rst_n = 1'b0; cmd = 16'h0000; cmd_valid = 1'b0; dmd_sig = 1'b0; cnt = 16'h0000;
      step(3);
      chk("init_state", state_dbg, 0);
      chk("init_tx", tx_data, 0);
      rst_n = 1'b1;
      step(2);

      // Three-frame acquisition with a count ramp
      w0 = wr_seen;
      send(4'd1, 3);
      pulse(16'd100); pulse(16'd200); pulse(16'd300); pulse(16'd400);
      chk("t1_busy", busy, 0);
      chk("t1_writes", wr_seen - w0, 3);
      status_expect("t1_status", 16'h4003);

      // Readback with pointer clear; fourth read runs past the written frames
      read_expect("pre_rd0", 16'h00C8);
      send(4'd5, 0);
      read_expect("rd0", 16'h00C8);
      read_expect("rd1", 16'h012C);
      read_expect("rd2", 16'h0190);
      read_expect("rd3_empty", 16'h0000);
      status_expect("rd_status", 16'h5003);

      // STOP after two frames
      w0 = wr_seen;
      send(4'd1, 5);
      pulse(16'd10); pulse(16'd11); pulse(16'd12);
      send(4'd2, 0);
      chk("t2_busy", busy, 0);
      pulse(16'd13); pulse(16'd14);
      chk("t2_writes", wr_seen - w0, 2);
      status_expect("t2_status", 16'h0002);

      // Saturation flag, cleared by the next START; START while busy
      send(4'd1, 2);
      pulse(16'd5); pulse(16'hFFFF); pulse(16'd7);
      status_expect("t3_sat", 16'h6002);
      send(4'd1, 1);
      status_expect("t3_restart", 16'h8000);
      send(4'd1, 4);
      status_expect("t3_busy_start", 16'h9000);
      pulse(16'd20); pulse(16'd21);
      status_expect("t3_n_kept", 16'h5001);

      // STOP in the same cycle as the closing edge
      send(4'd1, 2);
      pulse(16'd30);
      w0 = wr_seen;
      cnt = 16'd31;
      dmd_sig = 1'b1;
      step(3);
      cmd = {4'd2, 12'd0};
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0; cmd = 16'h0000; dmd_sig = 1'b0;
      step(GAP);
      chk("t5_no_write", wr_seen - w0, 0);
      status_expect("t5_status", 16'h0000);

      // Asynchronous reset while counting
      send(4'd1, 3);
      pulse(16'd40);
      chk("t6_cnt_en_pre", cnt_en, 1);
      status_expect("t6_tx_pre", 16'h8000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_cnt_en", cnt_en, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_mem_we", mem_we, 0);
      chk("t6_async_cnt_clr", cnt_clr, 0);
      chk("t6_async_tx", tx_data, 0);
      chk("t6_async_state", state_dbg, 0);
      step(3);
      rst_n = 1'b1;
      w0 = wr_seen;
      pulse(16'd41); pulse(16'd42);
      chk("t6_no_write", wr_seen - w0, 0);
      chk("t6_busy", busy, 0);
      status_expect("t6_status", 16'h0000);

      // New START after reset works normally
      send(4'd1, 1);
      pulse(16'd50); pulse(16'd51);
      status_expect("t7_status", 16'h4001);
      read_expect("t7_rd0", 16'd51);

      step(5);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
